apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 154 +++++++++++++++
 tb/tb_apb_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// ============================================================================
//  Module   : apb_master
//  Brief    : Single-outstanding APB master with one-hot select and timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module apb_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_id,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [NUM_SLAVES-1:0] apb_sel,
    output logic                  apb_enable,
    output logic                  apb_write,
    output logic [ADDR_W-1:0]     apb_addr,
    output logic [DATA_W-1:0]     apb_wdata,
    input  logic                  apb_ready,
    input  logic [DATA_W-1:0]     apb_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                r_state, w_state_n;
    logic [CNT_W-1:0]      r_wait_cnt, w_wait_cnt_n;
    logic                  w_cmd_ready_n, w_rsp_valid_n, w_rsp_err_n;
    logic [DATA_W-1:0]     w_rsp_rdata_n;
    logic [NUM_SLAVES-1:0] w_sel_n, w_sel_dec;
    logic                  w_enable_n, w_write_n, w_id_ok;
    logic [ADDR_W-1:0]     w_addr_n;
    logic [DATA_W-1:0]     w_wdata_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            apb_sel    <= '0;
            apb_enable <= 1'b0;
            apb_write  <= 1'b0;
            apb_addr   <= '0;
            apb_wdata  <= '0;
        end else begin
            r_state    <= w_state_n;
            r_wait_cnt <= w_wait_cnt_n;
            cmd_ready  <= w_cmd_ready_n;
            rsp_valid  <= w_rsp_valid_n;
            rsp_err    <= w_rsp_err_n;
            rsp_rdata  <= w_rsp_rdata_n;
            apb_sel    <= w_sel_n;
            apb_enable <= w_enable_n;
            apb_write  <= w_write_n;
            apb_addr   <= w_addr_n;
            apb_wdata  <= w_wdata_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_wait_cnt_n  = r_wait_cnt;
        w_rsp_valid_n = 1'b0;
        w_rsp_err_n   = rsp_err;
        w_rsp_rdata_n = rsp_rdata;
        w_sel_n       = apb_sel;
        w_enable_n    = apb_enable;
        w_write_n     = apb_write;
        w_addr_n      = apb_addr;
        w_wdata_n     = apb_wdata;
        w_id_ok       = ({30'd0, cmd_id} < 32'(NUM_SLAVES));
        w_sel_dec     = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_dec[i] = ({30'd0, cmd_id} == 32'(i));
        end

        case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (w_id_ok) begin
                        w_state_n  = SETUP;
                        w_sel_n    = w_sel_dec;
                        w_enable_n = 1'b0;
                        w_write_n  = cmd_write;
                        w_addr_n   = cmd_addr;
                        w_wdata_n  = cmd_wdata;
                    end else begin
                        // Unmapped slave index: answer with an error, bus untouched.
                        w_rsp_valid_n = 1'b1;
                        w_rsp_err_n   = 1'b1;
                        w_rsp_rdata_n = '0;
                    end
                end
            end
            SETUP: begin
                w_state_n    = ACCESS;
                w_enable_n   = 1'b1;
                w_wait_cnt_n = '0;
            end
            ACCESS: begin
                if (apb_ready) begin
                    w_state_n     = IDLE;
                    w_sel_n       = '0;
                    w_enable_n    = 1'b0;
                    w_rsp_valid_n = 1'b1;
                    w_rsp_err_n   = 1'b0;
                    w_rsp_rdata_n = apb_write ? '0 : apb_rdata;
                    w_wait_cnt_n  = '0;
                end else if (r_wait_cnt == C_LAST_WAIT) begin
                    // Ready checked first so a late ready on the last cycle still completes.
                    w_state_n     = IDLE;
                    w_sel_n       = '0;
                    w_enable_n    = 1'b0;
                    w_rsp_valid_n = 1'b1;
                    w_rsp_err_n   = 1'b1;
                    w_rsp_rdata_n = '0;
                    w_wait_cnt_n  = '0;
                end else begin
                    w_wait_cnt_n = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n  = IDLE;
                w_sel_n    = '0;
                w_enable_n = 1'b0;
            end
        endcase

        w_cmd_ready_n = (w_state_n == IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
//  Module   : tb_apb_master
//  Brief    : Scoreboard bench for apb_master (4-slave and 2-slave builds).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_master;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_valid2 = 1'b0, cmd_write = 1'b0;
    logic [1:0]    cmd_id = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          apb_ready = 1'b0;
    logic [DW-1:0] apb_rdata = '0;

    logic          cmd_ready, rsp_valid, rsp_err, apb_enable, apb_write;
    logic [DW-1:0] rsp_rdata, apb_wdata;
    logic [NS-1:0] apb_sel;
    logic [AW-1:0] apb_addr;

    logic          cmd_ready2, rsp_valid2, rsp_err2, apb_enable2, apb_write2;
    logic [DW-1:0] rsp_rdata2, apb_wdata2;
    logic [1:0]    apb_sel2;
    logic [AW-1:0] apb_addr2;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
        .apb_addr(apb_addr), .apb_wdata(apb_wdata),
        .apb_ready(apb_ready), .apb_rdata(apb_rdata)
    );

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(2), .TIMEOUT(TO)) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .apb_sel(apb_sel2), .apb_enable(apb_enable2), .apb_write(apb_write2),
        .apb_addr(apb_addr2), .apb_wdata(apb_wdata2),
        .apb_ready(apb_ready), .apb_rdata(apb_rdata)
    );

    // Response monitor: every rsp_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: rsp_valid=1 err=%0b rdata=%h, no command outstanding",
                         rsp_err, rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== mon_e) begin
                    bad++;
                    $display("FAIL rsp_data: got err=%0b rdata=%h, want err=%0b rdata=%h",
                             rsp_err, rsp_rdata, mon_e.err, mon_e.rdata);
                end
            end
        end
    end

    task automatic do_xfer(input logic wr, input logic [1:0] id, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int nwait, input string name);
        logic          exp_err;
        int            acc;
        logic [NS-1:0] sel;
        logic [DW-1:0] exp_rd;
        exp_err = (nwait >= TO);
        acc     = exp_err ? TO : nwait + 1;
        sel     = '0;
        sel[id] = 1'b1;
        exp_rd  = (exp_err || wr) ? '0 : rdata;

        @(posedge clk); #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle_ready: cmd_ready=%0b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_wdata = wdata;
        exp_q.push_back({exp_err, exp_rd});

        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        apb_rdata = rdata;
        total++;
        if ({cmd_ready, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata} !==
            {1'b0, sel, 1'b0, wr, addr, wdata}) begin
            bad++;
            $display("FAIL %s_setup: rdy=%0b sel=%b en=%0b wr=%0b addr=%h wd=%h want rdy=0 sel=%b en=0 wr=%0b addr=%h wd=%h",
                     name, cmd_ready, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata,
                     sel, wr, addr, wdata);
        end

        @(posedge clk); #1;
        for (int c = 0; c < acc; c++) begin
            apb_ready = (c == nwait);
            total++;
            if ({cmd_ready, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata} !==
                {1'b0, sel, 1'b1, wr, addr, wdata}) begin
                bad++;
                $display("FAIL %s_access%0d: rdy=%0b sel=%b en=%0b wr=%0b addr=%h wd=%h want rdy=0 sel=%b en=1 wr=%0b addr=%h wd=%h",
                         name, c, cmd_ready, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata,
                         sel, wr, addr, wdata);
            end
            @(posedge clk); #1;
        end
        apb_ready = 1'b0;

        total++;
        if ({cmd_ready, rsp_valid, apb_sel, apb_enable} !== {1'b1, 1'b1, {NS{1'b0}}, 1'b0}) begin
            bad++;
            $display("FAIL %s_done: rdy=%0b rsp_valid=%0b sel=%b en=%0b want rdy=1 rsp_valid=1 sel=0 en=0",
                     name, cmd_ready, rsp_valid, apb_sel, apb_enable);
        end

        @(posedge clk); #1;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata, apb_addr, apb_wdata} !==
            {1'b0, exp_err, exp_rd, addr, wdata}) begin
            bad++;
            $display("FAIL %s_hold: rsp_valid=%0b err=%0b rdata=%h addr=%h wd=%h want 0 %0b %h %h %h",
                     name, rsp_valid, rsp_err, rsp_rdata, apb_addr, apb_wdata,
                     exp_err, exp_rd, addr, wdata);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_rdata, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata}
            !== {1'b1, 1'b0, 1'b0, {DW{1'b0}}, {NS{1'b0}}, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}}) begin
            bad++;
            $display("FAIL reset_state: rdy=%0b rv=%0b err=%0b rd=%h sel=%b en=%0b wr=%0b addr=%h wd=%h want rdy=1, rest 0",
                     cmd_ready, rsp_valid, rsp_err, rsp_rdata, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata);
        end
        total++;
        if ({cmd_ready2, rsp_valid2, apb_sel2, apb_enable2} !== {1'b1, 1'b0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state2: rdy=%0b rv=%0b sel=%b en=%0b want 1 0 00 0",
                     cmd_ready2, rsp_valid2, apb_sel2, apb_enable2);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        do_xfer(1'b1, 2'd1, 8'h06, 8'h05, 8'hEE, 0, "write");
    endtask

    task automatic test_read();
        do_xfer(1'b0, 2'd1, 8'h06, 8'h00, 8'h05, 0, "read");
    endtask

    task automatic test_wait_states();
        do_xfer(1'b1, 2'd0, 8'h05, 8'h04, 8'h77, 5, "wait5");
        do_xfer(1'b0, 2'd3, 8'hC3, 8'h00, 8'h3C, TO - 1, "late_ready");
    endtask

    task automatic test_timeout();
        do_xfer(1'b0, 2'd2, 8'h81, 8'h00, 8'hAA, 1000, "timeout");
    endtask

    task automatic test_bad_id();
        @(posedge clk); #1;
        cmd_valid2 = 1'b1; cmd_write = 1'b1; cmd_id = 2'd3; cmd_addr = 8'h12; cmd_wdata = 8'h34;
        @(posedge clk); #1;
        cmd_valid2 = 1'b0;
        total++;
        if ({cmd_ready2, rsp_valid2, rsp_err2, rsp_rdata2, apb_sel2, apb_enable2} !==
            {1'b1, 1'b1, 1'b1, {DW{1'b0}}, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL bad_id_rsp: rdy=%0b rv=%0b err=%0b rd=%h sel=%b en=%0b want 1 1 1 00 00 0",
                     cmd_ready2, rsp_valid2, rsp_err2, rsp_rdata2, apb_sel2, apb_enable2);
        end
        @(posedge clk); #1;
        total++;
        if ({rsp_valid2, rsp_err2, apb_sel2, apb_enable2} !== {1'b0, 1'b1, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL bad_id_after: rv=%0b err=%0b sel=%b en=%0b want 0 1 00 0",
                     rsp_valid2, rsp_err2, apb_sel2, apb_enable2);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 2'd2; cmd_addr = 8'h09; cmd_wdata = 8'h5A;
        apb_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_rdata, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata}
            !== {1'b1, 1'b0, 1'b0, {DW{1'b0}}, {NS{1'b0}}, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}}) begin
            bad++;
            $display("FAIL reset_mid: rdy=%0b rv=%0b err=%0b rd=%h sel=%b en=%0b wr=%0b addr=%h wd=%h want rdy=1, rest 0",
                     cmd_ready, rsp_valid, rsp_err, rsp_rdata, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        do_xfer(1'b0, 2'd1, 8'h06, 8'h00, 8'h5B, 2, "after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_bad_id();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rsp_missing: %0d expected responses never arrived, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
